// File: rtl/uart_command_receiver_if.sv
// uart_command_receiver_if: host-link bundle between the UART byte stream, the filter and the command receiver.
// Signals:
//   rx_data/rx_valid   received UART byte and its one-cycle strobe
//   filter_done        filter finished the current result
//   command/busy       active opcode (0 when idle) and its non-zero flag
//   stop/error         one-cycle pulses for an accepted STOP or a rejected/timed-out opcode
//   ack_data/ack_valid/ack_ready  ACK/NAK byte handshake towards the UART transmitter
// Modports: master drives the host/filter side, slave is the command receiver.
interface uart_command_receiver_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        filter_done;
    logic [15:0] command;
    logic        stop;
    logic        busy;
    logic        error;
    logic [7:0]  ack_data;
    logic        ack_valid;
    logic        ack_ready;
    modport master (
        output rx_data, rx_valid, filter_done, ack_ready,
        input  command, stop, busy, error, ack_data, ack_valid
    );
    modport slave (
        input  rx_data, rx_valid, filter_done, ack_ready,
        output command, stop, busy, error, ack_data, ack_valid
    );
endinterface

// File: rtl/uart_command_receiver.sv
// uart_command_receiver: assembles 16-bit opcodes from UART bytes (high byte first), validates them and drives the filter command/stop.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   uart_command_receiver_if.slave (rx byte in, filter_done in, command/stop/busy/error out, ack handshake)
// Parameters: TIMEOUT_CYCLES (max cycles between high and low byte), CMD_WIDTH (fixed 16), STOP_OPCODE.
// Build option: define CMD_ACK_EN to emit an ACK (8'h06) / NAK (8'h15) byte per decoded opcode; otherwise ack outputs are tied 0.
module uart_command_receiver #(
    parameter int unsigned              TIMEOUT_CYCLES = 100000,
    parameter int unsigned              CMD_WIDTH      = 16,
    parameter logic [CMD_WIDTH-1:0]     STOP_OPCODE    = 16'hA0FF
) (
    input logic                    clk,
    input logic                    rst,
    uart_command_receiver_if.slave bus
);
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic {S_HI, S_LO} state_t;
    state_t               state_q;
    logic [7:0]           hi_q;
    logic [CW-1:0]        cnt_q;
    logic [CMD_WIDTH-1:0] command_q, command_d;
    logic                 stop_q, stop_d;
    logic                 error_q, error_d;
    logic [CMD_WIDTH-1:0] opcode;
    logic                 decode, timeout, known, is_stop, accept;
    assign opcode  = {hi_q, bus.rx_data};
    assign decode  = state_q == S_LO && bus.rx_valid;
    // Fires on the cycle the counter would reach TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES edges after the high byte.
    assign timeout = state_q == S_LO && !bus.rx_valid && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign known   = opcode inside {16'hA010, 16'hA020, 16'hA030, 16'hA040, 16'hA050, 16'hA060};
    assign is_stop = opcode == STOP_OPCODE;
    // filter_done frees the slot in the same cycle, so a coincident valid opcode is taken.
    assign accept  = decode && known && (command_q == '0 || bus.filter_done);
    always_comb begin
        stop_d    = decode && is_stop;
        error_d   = timeout || (decode && !is_stop && !accept);
        command_d = stop_d ? '0 : accept ? opcode : bus.filter_done ? '0 : command_q;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_HI;
            hi_q      <= '0;
            cnt_q     <= '0;
            command_q <= '0;
            stop_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            command_q <= command_d;
            stop_q    <= stop_d;
            error_q   <= error_d;
            case (state_q)
                S_HI: if (bus.rx_valid) begin
                    hi_q    <= bus.rx_data;
                    cnt_q   <= '0;
                    state_q <= S_LO;
                end
                S_LO: if (bus.rx_valid || timeout) begin
                    state_q <= S_HI;
                end else if (cnt_q != CW'(TIMEOUT_CYCLES)) begin
                    cnt_q <= cnt_q + CW'(1);
                end
                default: state_q <= S_HI;
            endcase
        end
    end
    assign bus.command = command_q;
    assign bus.busy    = command_q != '0;
    assign bus.stop    = stop_q;
    assign bus.error   = error_q;
`ifdef CMD_ACK_EN
    logic [7:0] ack_data_q;
    logic       ack_valid_q;
    // A fresh response overrides a pending one and wins over a same-cycle ack_ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ack_valid_q <= 1'b0;
            ack_data_q  <= '0;
        end else if (decode || timeout) begin
            ack_valid_q <= 1'b1;
            ack_data_q  <= (stop_d || accept) ? 8'h06 : 8'h15;
        end else if (bus.ack_ready) begin
            ack_valid_q <= 1'b0;
        end
    end
    assign bus.ack_data  = ack_data_q;
    assign bus.ack_valid = ack_valid_q;
`else
    logic unused_ack_ready;
    assign unused_ack_ready = bus.ack_ready;
    assign bus.ack_data     = '0;
    assign bus.ack_valid    = 1'b0;
`endif
endmodule
